block_transfer_sequencer: RTL and testbench

//  Multi-register load/store sequencer (LDM/STM, increment-after) for the single-cycle ARM-style CPU.

---
 rtl/bts_pkg.sv | 13 +
 rtl/block_transfer_sequencer_lsb.sv | 20 ++
 rtl/block_transfer_sequencer.sv | 145 ++++++++++++++
 tb/tb_block_transfer_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bts_pkg.sv
// Shared types and constants for the block transfer sequencer.
package bts_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        WBACK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/block_transfer_sequencer_lsb.sv
// Priority encoder: returns the index of the lowest set bit and whether any bit is set.
module lowest_set_bit #(
    parameter int W  = 16,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  list_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        idx_o = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (list_i[i]) idx_o = IW'(i);
        end
    end

    assign any_o = |list_i;

endmodule

// File: rtl/block_transfer_sequencer.sv
// LDM/STM increment-after sequencer: one register per memory handshake, lowest index first.
// Base-register writeback is built only when BTS_WRITEBACK_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; latches list, base, direction
// XFER  | first cycle raises mem_req, then one beat per mem_ack
// WBACK | base register update (writeback builds only)
// DONE  | one-cycle completion pulse
module block_transfer_sequencer
    import bts_pkg::*;
#(
    parameter int N = 4,
    parameter int M = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             is_load_i,
    input  logic [2**N-1:0]  reg_list_i,
    input  logic [M-1:0]     base_addr_i,
    input  logic [N-1:0]     base_reg_i,
    output logic [N-1:0]     rf_a1_o,
    input  logic [M-1:0]     rf_rd1_i,
    output logic             rf_we3_o,
    output logic [N-1:0]     rf_a3_o,
    output logic [M-1:0]     rf_wd3_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [M-1:0]     mem_addr_o,
    output logic [M-1:0]     mem_wdata_o,
    input  logic [M-1:0]     mem_rdata_i,
    input  logic             mem_ack_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pc_loaded_o
);

    localparam int W = 2**N;

`ifdef BTS_WRITEBACK_EN
    localparam state_t AFTER_XFER = WBACK;
`else
    localparam state_t AFTER_XFER = DONE;
`endif

    state_t         state_q;
    logic [W-1:0]   pend_q;
    logic [W-1:0]   pend_d;
    logic [M-1:0]   addr_q;
    logic           is_load_q;
    logic           mem_req_q;
    logic           pc_q;
    logic [N-1:0]   idx;
    logic           any;
    logic           beat;
    logic           load_wr;
    logic           unused_ok;

`ifdef BTS_WRITEBACK_EN
    logic [N-1:0]   base_reg_q;
    logic           wb_skip_q;
    logic           wb_wr;
`endif

    lowest_set_bit #(.W(W), .IW(N)) u_lsb (
        .list_i (pend_q),
        .idx_o  (idx),
        .any_o  (any)
    );

    assign beat    = (state_q == XFER) & mem_req_q & mem_ack_i & any;
    assign load_wr = beat & is_load_q;
    assign pend_d  = pend_q & ~(W'(1) << idx);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            addr_q     <= '0;
            is_load_q  <= 1'b0;
            mem_req_q  <= 1'b0;
            pc_q       <= 1'b0;
`ifdef BTS_WRITEBACK_EN
            base_reg_q <= '0;
            wb_skip_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        pend_q     <= reg_list_i;
                        addr_q     <= base_addr_i & ~M'(3);
                        is_load_q  <= is_load_i;
                        pc_q       <= 1'b0;
`ifdef BTS_WRITEBACK_EN
                        base_reg_q <= base_reg_i;
                        wb_skip_q  <= is_load_i & reg_list_i[base_reg_i];
`endif
                        state_q    <= (reg_list_i == '0) ? DONE : XFER;
                    end
                end
                XFER: begin
                    if (!mem_req_q) begin
                        mem_req_q <= 1'b1;
                    end else if (beat) begin
                        pend_q <= pend_d;
                        addr_q <= addr_q + M'(WORD_BYTES);
                        if (is_load_q && (&idx)) pc_q <= 1'b1;
                        if (pend_d == '0) begin
                            mem_req_q <= 1'b0;
                            state_q   <= AFTER_XFER;
                        end
                    end
                end
                WBACK:   state_q <= DONE;
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rf_a1_o     = idx;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_req_q & ~is_load_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = mem_req_q ? rf_rd1_i : '0;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign pc_loaded_o = (state_q == DONE) & pc_q;

`ifdef BTS_WRITEBACK_EN
    // addr_q has advanced once per beat, so it already holds base + 4*count.
    assign wb_wr     = (state_q == WBACK) & ~wb_skip_q;
    assign rf_we3_o  = load_wr | wb_wr;
    assign rf_a3_o   = load_wr ? idx : (wb_wr ? base_reg_q : '0);
    assign rf_wd3_o  = load_wr ? mem_rdata_i : (wb_wr ? addr_q : '0);
    assign unused_ok = ^base_addr_i[1:0];
`else
    assign rf_we3_o  = load_wr;
    assign rf_a3_o   = load_wr ? idx : '0;
    assign rf_wd3_o  = load_wr ? mem_rdata_i : '0;
    assign unused_ok = ^{base_addr_i[1:0], base_reg_i};
`endif

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Directed bench for block_transfer_sequencer; writeback cases build when BTS_WRITEBACK_EN is defined.
module tb_block_transfer_sequencer;

`ifdef BTS_WRITEBACK_EN
    localparam int WB = 1;
`else
    localparam int WB = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_load;
    logic [15:0] reg_list;
    logic [31:0] base_addr;
    logic [3:0]  base_reg;
    logic [3:0]  rf_a1;
    logic [31:0] rf_rd1;
    logic        rf_we3;
    logic [3:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        busy;
    logic        done;
    logic        pc_loaded;

    logic [31:0] rf [16];
    logic [31:0] rdata_tbl [16];
    logic [31:0] ma_q[$], md_q[$], wd_q[$];
    logic        mw_q[$];
    logic [3:0]  wa_q[$];
    int          n_chk = 0, n_bad = 0;
    int          waits_cfg = 0, wcnt = 0, beat_i = 0, stab_bad = 0, done_cnt = 0;
    logic        pc_at_done = 1'b0;
    logic [31:0] a0, d0;
    int          lat;

    always #5 clk = ~clk;

    assign rf_rd1 = rf[rf_a1];

    block_transfer_sequencer #(.N(4), .M(32)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .is_load_i(is_load),
        .reg_list_i(reg_list), .base_addr_i(base_addr), .base_reg_i(base_reg),
        .rf_a1_o(rf_a1), .rf_rd1_i(rf_rd1), .rf_we3_o(rf_we3), .rf_a3_o(rf_a3),
        .rf_wd3_o(rf_wd3), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .mem_ack_i(mem_ack), .busy_o(busy), .done_o(done), .pc_loaded_o(pc_loaded)
    );

    // memory responder: acks after waits_cfg wait cycles, checks request stability meanwhile
    always @(negedge clk) begin
        if (mem_ack) wcnt = 0;
        mem_ack = 1'b0;
        if (mem_req && !rst) begin
            if (wcnt == 0) begin
                a0 = mem_addr;
                d0 = mem_wdata;
            end else if (mem_addr !== a0 || mem_wdata !== d0) begin
                stab_bad++;
            end
            if (wcnt == waits_cfg) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata_tbl[beat_i];
                beat_i++;
                ma_q.push_back(mem_addr);
                md_q.push_back(mem_wdata);
                mw_q.push_back(mem_we);
            end else begin
                wcnt++;
            end
        end
    end

    // register-file model and completion monitor, sampled just before the rising edge
    always @(negedge clk) begin
        #4;
        if (rf_we3) begin
            rf[rf_a3] = rf_wd3;
            wa_q.push_back(rf_a3);
            wd_q.push_back(rf_wd3);
        end
        if (done) begin
            done_cnt++;
            pc_at_done = pc_loaded;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic clear_logs(input int waits);
        ma_q.delete(); md_q.delete(); mw_q.delete(); wa_q.delete(); wd_q.delete();
        waits_cfg = waits; wcnt = 0; beat_i = 0; stab_bad = 0; done_cnt = 0; pc_at_done = 1'b0;
    endtask

    task automatic drive_start(input logic ld, input logic [15:0] list, input logic [31:0] base,
                               input logic [3:0] breg);
        @(posedge clk); #1;
        is_load = ld; reg_list = list; base_addr = base; base_reg = breg; start = 1'b1;
        @(posedge clk); #1;
        // scramble the inputs: the sequencer must work from its latched copies
        start = 1'b0; is_load = ~ld; reg_list = 16'hFFFF; base_addr = 32'hDEAD_BEE0; base_reg = ~breg;
    endtask

    task automatic run(input logic ld, input logic [15:0] list, input logic [31:0] base,
                       input logic [3:0] breg, input int waits, input logic glitch, output int cyc);
        clear_logs(waits);
        drive_start(ld, list, base, breg);
        cyc = 1;
        chk("busy_c1", busy, 1);
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            start = glitch && (cyc == 2);
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; is_load = 1'b0; reg_list = '0; base_addr = '0; base_reg = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            rf[i] = 32'h1000 + i;
            rdata_tbl[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we3", rf_we3, 0);
        rst = 1'b0;

        // LDM R1,R3 from 0x100, zero wait states
        rdata_tbl[0] = 32'hAA; rdata_tbl[1] = 32'hBB;
        run(1'b1, 16'h000A, 32'h100, 4'd13, 0, 1'b0, lat);
        chk("ldm_lat", lat, 4 + WB);
        chk("ldm_nwr", wa_q.size(), 2 + WB);
        chk("ldm_a0", wa_q[0], 1);
        chk("ldm_d0", wd_q[0], 32'hAA);
        chk("ldm_a1", wa_q[1], 3);
        chk("ldm_d1", wd_q[1], 32'hBB);
        chk("ldm_m0", ma_q[0], 32'h100);
        chk("ldm_m1", ma_q[1], 32'h104);
        chk("ldm_we", mw_q[0], 0);
        chk("ldm_pc", pc_at_done, 0);
        chk("ldm_dcnt", done_cnt, 1);
`ifdef BTS_WRITEBACK_EN
        chk("ldm_wb_a", wa_q[2], 13);
        chk("ldm_wb_d", wd_q[2], 32'h108);
`endif

        // STM R0,R15 to 0x200, two wait states per beat
        rf[0] = 32'h11; rf[15] = 32'h22;
        run(1'b0, 16'h8001, 32'h200, 4'd2, 2, 1'b0, lat);
        chk("stm_lat", lat, 8 + WB);
        chk("stm_nmem", ma_q.size(), 2);
        chk("stm_m0", ma_q[0], 32'h200);
        chk("stm_d0", md_q[0], 32'h11);
        chk("stm_m1", ma_q[1], 32'h204);
        chk("stm_d1", md_q[1], 32'h22);
        chk("stm_we", mw_q[1], 1);
        chk("stm_stable", stab_bad, 0);
        chk("stm_nwr", wa_q.size(), WB);

        // empty list
        run(1'b1, 16'h0000, 32'h300, 4'd0, 0, 1'b0, lat);
        chk("zero_lat", lat, 1);
        chk("zero_nmem", ma_q.size(), 0);
        chk("zero_nwr", wa_q.size(), 0);
        chk("zero_dcnt", done_cnt, 1);

        // reset in the middle of a 3-beat LDM, during the second beat's ack
        clear_logs(0);
        rdata_tbl[0] = 32'h1; rdata_tbl[1] = 32'h2; rdata_tbl[2] = 32'h3;
        drive_start(1'b1, 16'h0007, 32'h400, 4'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); #2;
        chk("mid_we3", rf_we3, 1);
        chk("mid_nwr", wa_q.size(), 1);
        rst = 1'b1;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_we3", rf_we3, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rdata_tbl[0] = 32'h31; rdata_tbl[1] = 32'h32; rdata_tbl[2] = 32'h33;
        run(1'b1, 16'h0007, 32'h400, 4'd0, 0, 1'b0, lat);
        chk("rerun_lat", lat, 5 + WB);
        chk("rerun_nwr", wa_q.size(), 3);
        chk("rerun_a2", wa_q[2], 2);
        chk("rerun_d2", wd_q[2], 32'h33);
        chk("rerun_m0", ma_q[0], 32'h400);

        // LDM R0,R15 wrapping past the top of memory, start pulsed while busy
        rdata_tbl[0] = 32'h55; rdata_tbl[1] = 32'h66;
        run(1'b1, 16'h8001, 32'hFFFF_FFFC, 4'd15, 1, 1'b1, lat);
        chk("pc_lat", lat, 6 + WB);
        chk("pc_m0", ma_q[0], 32'hFFFF_FFFC);
        chk("pc_m1", ma_q[1], 32'h0);
        chk("pc_a1", wa_q[1], 15);
        chk("pc_d1", wd_q[1], 32'h66);
        chk("pc_nwr", wa_q.size(), 2);
        chk("pc_loaded", pc_at_done, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("pc_dcnt", done_cnt, 1);
        chk("pc_idle", busy, 0);

        // unaligned base, base register inside the load list
        rdata_tbl[0] = 32'h77; rdata_tbl[1] = 32'h88;
        run(1'b1, 16'h2002, 32'h702, 4'd13, 0, 1'b0, lat);
        chk("ua_lat", lat, 4 + WB);
        chk("ua_m0", ma_q[0], 32'h700);
        chk("ua_nwr", wa_q.size(), 2);
        chk("ua_a1", wa_q[1], 13);
        chk("ua_d1", wd_q[1], 32'h88);

`ifdef BTS_WRITEBACK_EN
        // STM R0-R2 from 0x300 with writeback into R13
        run(1'b0, 16'h0007, 32'h300, 4'd13, 0, 1'b0, lat);
        chk("wb_lat", lat, 6);
        chk("wb_nwr", wa_q.size(), 1);
        chk("wb_a", wa_q[0], 13);
        chk("wb_d", wd_q[0], 32'h30C);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
